// File: rtl/bn128_multiexp_demux_pkg.sv
// -----------------------------------------------------------------------------
// bn128_multiexp_demux_pkg
// Shared constants and types for the BN128 multiexp host-stream demux:
//   DAT_BITS          - scalar width used by the multiexp core
//   CTL_BITS          - width of the stream side-band control field
//   MULTIEXP_MAX_LOG2 - largest job size (log2 of pair count) accepted
//   HDR_LOG2_LO/HI    - bit range of log2_num_in inside the header beat
//   demux_state_t     - packet parser states
// -----------------------------------------------------------------------------
package bn128_multiexp_demux_pkg;

  localparam int DAT_BITS          = 256;
  localparam int CTL_BITS          = 8;
  localparam int MULTIEXP_MAX_LOG2 = 20;
  localparam int HDR_LOG2_LO       = 0;
  localparam int HDR_LOG2_HI       = 31;

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_PNT   = 2'd1,
    ST_SCL   = 2'd2,
    ST_FLUSH = 2'd3
  } demux_state_t;

endpackage

// File: rtl/bn128_multiexp_demux_if.sv
// -----------------------------------------------------------------------------
// if_axi_stream
// Minimal AXI-stream style bundle used on every port of the demux.
//   val/rdy  - handshake, a beat moves when both are high on a clock edge
//   sop/eop  - packet framing
//   dat      - payload, DAT_BITS wide
//   ctl/err/mod - side-band fields, carried but unused by the demux
// Modports: master drives payload and val, slave drives rdy.
// -----------------------------------------------------------------------------
interface if_axi_stream #(
  parameter int DAT_BITS = 512
) ();
  import bn128_multiexp_demux_pkg::CTL_BITS;

  localparam int MOD_BITS = (DAT_BITS / 8 > 1) ? $clog2(DAT_BITS / 8) : 1;

  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic [MOD_BITS-1:0] mod;

  modport master (output val, sop, eop, dat, ctl, err, mod, input rdy);
  modport slave  (input val, sop, eop, dat, ctl, err, mod, output rdy);

endinterface

// File: rtl/bn128_multiexp_demux_axis_out_reg.sv
// -----------------------------------------------------------------------------
// bn128_multiexp_demux_axis_out_reg
// Single-entry registered stream source. A load fills the register and raises
// val; a handshake empties it. A load in the same cycle as a drain keeps val
// high with the new data, so the source can run at one beat per cycle.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_load, i_dat  - write strobe and payload
//   o_if           - stream source (sop=eop=1 on every beat, ctl/err/mod=0)
// -----------------------------------------------------------------------------
module bn128_multiexp_demux_axis_out_reg #(
  parameter int DAT_BITS = 512
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic [DAT_BITS-1:0] i_dat,
  if_axi_stream.master        o_if
);

  logic                val_r;
  logic                frm_r;
  logic [DAT_BITS-1:0] dat_r;

  // Valid flag: load wins over drain so back-to-back beats never bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      val_r <= 1'b0;
    end else if (i_load) begin
      val_r <= 1'b1;
    end else if (val_r && o_if.rdy) begin
      val_r <= 1'b0;
    end else begin
      val_r <= val_r;
    end
  end

  // Payload and framing bits, captured on load only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dat_r <= '0;
      frm_r <= 1'b0;
    end else if (i_load) begin
      dat_r <= i_dat;
      frm_r <= 1'b1;
    end else begin
      dat_r <= dat_r;
      frm_r <= frm_r;
    end
  end

  assign o_if.val = val_r;
  assign o_if.dat = dat_r;
  assign o_if.sop = frm_r;
  assign o_if.eop = frm_r;
  assign o_if.ctl = '0;
  assign o_if.err = 1'b0;
  assign o_if.mod = '0;

endmodule

// File: rtl/bn128_multiexp_demux.sv
// -----------------------------------------------------------------------------
// bn128_multiexp_demux
// Splits the host packet (header, then N = 2^log2 point/scalar pairs) into a
// point stream and a scalar stream for the multiexp wrapper.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_host_if      - host packet stream (sink)
//   o_pnt_if       - affine points, x in [255:0], y in [511:256] (source)
//   o_scl_if       - scalars (source)
//   o_log2_num_in  - job size from the last valid header
//   o_busy         - high while a job's pairs are being received
//   o_err          - sticky protocol error, cleared by the next valid header
// -----------------------------------------------------------------------------
module bn128_multiexp_demux
  import bn128_multiexp_demux_pkg::*;
#(
  parameter int IN_BITS  = 512,
  parameter int SCL_BITS = DAT_BITS,
  parameter int MAX_LOG2 = MULTIEXP_MAX_LOG2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  if_axi_stream.slave  i_host_if,
  if_axi_stream.master o_pnt_if,
  if_axi_stream.master o_scl_if,
  output logic [31:0]  o_log2_num_in,
  output logic         o_busy,
  output logic         o_err
);

  demux_state_t state_r, state_nxt_s;
  logic [32:0]  cnt_r;
  logic [31:0]  log2_r;
  logic         busy_r;
  logic         err_r;

  logic         host_rdy_s;
  logic         acc_s;
  logic [31:0]  hdr_log2_s;
  logic         hdr_ok_s;
  logic [32:0]  cnt_nxt_s;
  logic         last_s;
  logic         ld_hdr_s;
  logic         set_err_s;
  logic         cnt_inc_s;
  logic         pnt_load_s;
  logic         scl_load_s;

  assign hdr_log2_s = i_host_if.dat[HDR_LOG2_HI:HDR_LOG2_LO];
  assign hdr_ok_s   = i_host_if.sop && (hdr_log2_s <= 32'(MAX_LOG2));
  assign cnt_nxt_s  = cnt_r + 33'd1;
  assign last_s     = (cnt_nxt_s == (33'd1 << log2_r));

  // A header waits for both outputs to empty so jobs never overlap; data
  // states only wait on the register they are about to load.
  assign host_rdy_s = (state_r == ST_HDR) ? (!o_pnt_if.val && !o_scl_if.val) :
                      (state_r == ST_PNT) ? (!o_pnt_if.val || o_pnt_if.rdy) :
                      (state_r == ST_SCL) ? (!o_scl_if.val || o_scl_if.rdy) :
                      1'b1;
  assign acc_s          = i_host_if.val && host_rdy_s;
  assign i_host_if.rdy  = host_rdy_s;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HDR: begin
        if (!acc_s)                state_nxt_s = ST_HDR;
        else if (hdr_ok_s)         state_nxt_s = ST_PNT;
        else if (i_host_if.eop)    state_nxt_s = ST_HDR;
        else                       state_nxt_s = ST_FLUSH;
      end
      ST_PNT: begin
        if (!acc_s)                state_nxt_s = ST_PNT;
        else if (i_host_if.eop)    state_nxt_s = ST_HDR;
        else                       state_nxt_s = ST_SCL;
      end
      ST_SCL: begin
        if (!acc_s)                state_nxt_s = ST_SCL;
        else if (last_s)           state_nxt_s = i_host_if.eop ? ST_HDR : ST_FLUSH;
        else if (i_host_if.eop)    state_nxt_s = ST_HDR;
        else                       state_nxt_s = ST_PNT;
      end
      ST_FLUSH: begin
        if (acc_s && i_host_if.eop) state_nxt_s = ST_HDR;
        else                        state_nxt_s = ST_FLUSH;
      end
      default: state_nxt_s = ST_HDR;
    endcase
  end

  // Per-state strobes for the output registers, counter and flags.
  always_comb begin
    ld_hdr_s   = 1'b0;
    set_err_s  = 1'b0;
    cnt_inc_s  = 1'b0;
    pnt_load_s = 1'b0;
    scl_load_s = 1'b0;
    case (state_r)
      ST_HDR: begin
        ld_hdr_s  = acc_s && hdr_ok_s;
        set_err_s = acc_s && !hdr_ok_s;
      end
      ST_PNT: begin
        pnt_load_s = acc_s && !i_host_if.eop;
        set_err_s  = acc_s && i_host_if.eop;
      end
      ST_SCL: begin
        scl_load_s = acc_s;
        cnt_inc_s  = acc_s;
        // Error when eop disagrees with the pair count: early or missing eop.
        set_err_s  = acc_s && (last_s != i_host_if.eop);
      end
      ST_FLUSH: begin
        ld_hdr_s = 1'b0;
      end
      default: begin
        ld_hdr_s = 1'b0;
      end
    endcase
  end

  // Job size, pair counter and status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      log2_r <= 32'd0;
      cnt_r  <= 33'd0;
      err_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      if (ld_hdr_s) begin
        log2_r <= hdr_log2_s;
        cnt_r  <= 33'd0;
        err_r  <= 1'b0;
      end else begin
        log2_r <= log2_r;
        cnt_r  <= cnt_inc_s ? cnt_nxt_s : cnt_r;
        err_r  <= err_r | set_err_s;
      end
      // Busy exactly while the parser is inside a job's pair section.
      busy_r <= (state_nxt_s == ST_PNT) || (state_nxt_s == ST_SCL);
    end
  end

  assign o_log2_num_in = log2_r;
  assign o_busy        = busy_r;
  assign o_err         = err_r;

  bn128_multiexp_demux_axis_out_reg #(.DAT_BITS(512)) u_pnt_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (pnt_load_s),
    .i_dat   (i_host_if.dat[511:0]),
    .o_if    (o_pnt_if)
  );

  bn128_multiexp_demux_axis_out_reg #(.DAT_BITS(SCL_BITS)) u_scl_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (scl_load_s),
    .i_dat   (i_host_if.dat[SCL_BITS-1:0]),
    .o_if    (o_scl_if)
  );

endmodule

// File: tb/tb_bn128_multiexp_demux.sv
// -----------------------------------------------------------------------------
// tb_bn128_multiexp_demux
// Drives host packets with random payloads, stalls and downstream backpressure.
// Expected point/scalar streams and flag values are built from the packet
// layout: a good header emits every pair sent, a bad header emits nothing,
// and err is set whenever the pair count disagrees with 2^log2.
// -----------------------------------------------------------------------------
module tb_bn128_multiexp_demux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_axi_stream #(.DAT_BITS(512)) host_if ();
  if_axi_stream #(.DAT_BITS(512)) pnt_if ();
  if_axi_stream #(.DAT_BITS(256)) scl_if ();

  logic [31:0] log2_num_in;
  logic        busy;
  logic        err;

  bn128_multiexp_demux dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_host_if     (host_if),
    .o_pnt_if      (pnt_if),
    .o_scl_if      (scl_if),
    .o_log2_num_in (log2_num_in),
    .o_busy        (busy),
    .o_err         (err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;       // 0: always ready, 1: random, 2: never ready
  int cur_kind = 3;       // 0 header, 1 point, 2 scalar, 3 idle
  bit chk_rdy = 1'b0;
  int first_acc = -1;
  int last_acc = 0;
  int last_good_log2 = 0;

  logic [511:0] exp_pnt[$];
  logic [511:0] got_pnt[$];
  logic [255:0] exp_scl[$];
  logic [255:0] got_scl[$];

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready generator, changes just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       begin pnt_if.rdy = 1'b1; scl_if.rdy = 1'b1; end
      1:       begin pnt_if.rdy = 1'($urandom_range(0, 1)); scl_if.rdy = 1'($urandom_range(0, 1)); end
      default: begin pnt_if.rdy = 1'b0; scl_if.rdy = 1'b0; end
    endcase
  end

  // Monitor on the falling edge: records handshakes that complete at the next
  // rising edge and checks the host ready rule for the beat being offered.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (pnt_if.val && pnt_if.rdy) begin
        got_pnt.push_back(pnt_if.dat);
        check_eq("pnt_frame", {pnt_if.sop, pnt_if.eop}, 2'b11);
      end
      if (scl_if.val && scl_if.rdy) got_scl.push_back(scl_if.dat);
      if (host_if.val && host_if.rdy) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (chk_rdy && host_if.val) begin
        case (cur_kind)
          0: check_eq("rdy_hdr", host_if.rdy, !pnt_if.val && !scl_if.val);
          1: check_eq("rdy_pnt", host_if.rdy, !pnt_if.val || pnt_if.rdy);
          2: check_eq("rdy_scl", host_if.rdy, !scl_if.val || scl_if.rdy);
          default: ;
        endcase
      end
    end
  end

  // Offers one beat, starting just after a rising edge; returns just after the
  // edge that accepted it.
  task automatic send_beat(input int kind, input bit sop, input bit eop,
                           input logic [511:0] dat, input bit stall);
    bit ok = 1'b0;
    if (stall && ($urandom_range(0, 3) == 0)) begin
      host_if.val = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    cur_kind    = kind;
    host_if.val = 1'b1;
    host_if.sop = sop;
    host_if.eop = eop;
    host_if.dat = dat;
    for (int w = 0; w < 1000 && !ok; w++) begin
      @(negedge clk);
      ok = host_if.rdy;
      @(posedge clk);
      #1;
    end
    check_eq("host_acc", ok, 1'b1);
  endtask

  task automatic send_packet(input bit hdr_sop, input int log2, input int npairs,
                             input bit idx_scl, input bit stall, input bit chk);
    bit           good = hdr_sop && (log2 <= 20);
    int           n = (log2 <= 20) ? (1 << log2) : 0;
    logic [511:0] p;
    logic [255:0] s;
    logic [31:0]  l2 = 32'(log2);
    chk_rdy = chk;
    send_beat(0, hdr_sop, 1'b0, {480'd0, l2}, stall);
    if (good) begin
      last_good_log2 = log2;
      check_eq("busy_after_hdr", busy, 1'b1);
    end
    check_eq("log2_out", log2_num_in, 32'(last_good_log2));
    for (int i = 0; i < npairs; i++) begin
      p = {rnd256(), rnd256()};
      s = idx_scl ? 256'(i) : rnd256();
      if (good) begin
        exp_pnt.push_back(p);
        exp_scl.push_back(s);
      end
      send_beat(1, 1'b0, 1'b0, p, stall);
      send_beat(2, 1'b0, (i == npairs - 1), {256'd0, s}, stall);
    end
    host_if.val = 1'b0;
    cur_kind    = 3;
    chk_rdy     = 1'b0;
    check_eq("err_end", err, (!good) || (npairs != n));
    check_eq("busy_end", busy, 1'b0);
  endtask

  task automatic drain_compare(input string tag);
    int w = 0;
    @(negedge clk);
    while ((pnt_if.val || scl_if.val) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_drain"}, (w < 2000), 1'b1);
    @(posedge clk);
    #1;
    check_eq({tag, "_npnt"}, got_pnt.size(), exp_pnt.size());
    check_eq({tag, "_nscl"}, got_scl.size(), exp_scl.size());
    for (int i = 0; i < exp_pnt.size() && i < got_pnt.size(); i++)
      check_eq({tag, "_pnt"}, got_pnt[i], exp_pnt[i]);
    for (int i = 0; i < exp_scl.size() && i < got_scl.size(); i++)
      check_eq({tag, "_scl"}, got_scl[i], exp_scl[i]);
    exp_pnt.delete();
    got_pnt.delete();
    exp_scl.delete();
    got_scl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    host_if.val = 1'b0;
    host_if.sop = 1'b0;
    host_if.eop = 1'b0;
    host_if.dat = '0;
    host_if.ctl = '0;
    host_if.err = 1'b0;
    host_if.mod = '0;
    pnt_if.rdy  = 1'b1;
    scl_if.rdy  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pnt_val", pnt_if.val, 1'b0);
    check_eq("rst_scl_val", scl_if.val, 1'b0);
    check_eq("rst_pnt_dat", {pnt_if.sop, pnt_if.eop, pnt_if.dat}, 514'd0);
    check_eq("rst_scl_dat", {scl_if.sop, scl_if.eop, scl_if.dat}, 258'd0);
    check_eq("rst_flags", {log2_num_in, busy, err}, 34'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Minimal job: point (1,2), scalar 5
    chk_rdy = 1'b1;
    send_beat(0, 1'b1, 1'b0, 512'd0, 1'b0);
    check_eq("min_busy", busy, 1'b1);
    check_eq("min_log2", log2_num_in, 32'd0);
    exp_pnt.push_back({256'd2, 256'd1});
    send_beat(1, 1'b0, 1'b0, {256'd2, 256'd1}, 1'b0);
    exp_scl.push_back(256'd5);
    send_beat(2, 1'b0, 1'b1, 512'd5, 1'b0);
    host_if.val = 1'b0;
    chk_rdy = 1'b0;
    check_eq("min_busy_end", busy, 1'b0);
    check_eq("min_err", err, 1'b0);
    drain_compare("min");

    // Streaming: 8 pairs back to back, scalar = index
    first_acc = -1;
    send_packet(1'b1, 3, 8, 1'b1, 1'b0, 1'b1);
    check_eq("stream_cycles", last_acc - first_acc, 16);
    drain_compare("stream");

    // Backpressure with random downstream ready and host stalls
    rdy_mode = 1;
    for (int r = 0; r < 4; r++) begin
      send_packet(1'b1, 2, 4, 1'b0, 1'b1, 1'b1);
      drain_compare("bp");
    end
    rdy_mode = 0;

    // Oversized job, flushed to eop, then cleared by a good header
    send_packet(1'b1, 25, 2, 1'b0, 1'b0, 1'b0);
    drain_compare("big");
    send_packet(1'b1, 0, 1, 1'b0, 1'b0, 1'b1);
    drain_compare("big_clr");

    // Header without sop
    send_packet(1'b0, 1, 2, 1'b0, 1'b0, 1'b0);
    drain_compare("nosop");
    send_packet(1'b1, 1, 2, 1'b0, 1'b1, 1'b1);
    drain_compare("nosop_clr");

    // Early eop on the 2nd scalar of a 4-pair job
    send_packet(1'b1, 2, 2, 1'b0, 1'b0, 1'b1);
    drain_compare("early");
    send_packet(1'b1, 1, 2, 1'b0, 1'b0, 1'b1);
    drain_compare("early_clr");

    // Asynchronous reset with a point pending in the output register
    send_beat(0, 1'b1, 1'b0, 512'd1, 1'b0);
    rdy_mode = 2;
    pnt_if.rdy = 1'b0;
    scl_if.rdy = 1'b0;
    send_beat(1, 1'b0, 1'b0, {rnd256(), rnd256()}, 1'b0);
    host_if.val = 1'b0;
    check_eq("ar_pending", pnt_if.val, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_pnt_val", pnt_if.val, 1'b0);
    check_eq("ar_scl_val", scl_if.val, 1'b0);
    check_eq("ar_pnt_dat", pnt_if.dat, 512'd0);
    check_eq("ar_flags", {log2_num_in, busy, err}, 34'd0);
    exp_pnt.delete();
    got_pnt.delete();
    exp_scl.delete();
    got_scl.delete();
    last_good_log2 = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    pnt_if.rdy = 1'b1;
    scl_if.rdy = 1'b1;
    @(posedge clk);
    #1;
    send_packet(1'b1, 1, 2, 1'b0, 1'b0, 1'b1);
    drain_compare("ar_job");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bn128_multiexp_demux.md
# bn128_multiexp_demux

Upstream feeder for the BN128 multi-exponentiation wrapper. Accepts one 512-bit host AXI stream carrying a header beat followed by interleaved affine-point and scalar beats, and splits it into the separate point stream and scalar stream the multiexp wrapper joins. It also captures the job size, `log2_num_in`. Each output is registered, the block sustains one input beat per cycle, and malformed packets are flagged and flushed.

## Interface
- `IN_BITS`, default 512: host beat width; must be at least 512.
- `SCL_BITS`, default 256: scalar width; equals `bn128_pkg::DAT_BITS`.
- `MAX_LOG2`, default 20: largest accepted `log2_num_in`.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_host_if`  sink  `if_axi_stream` with `DAT_BITS=IN_BITS`  host packet stream.
- `o_pnt_if`  source  `if_axi_stream` with `DAT_BITS=512`  affine point: x in `[255:0]`, y in `[511:256]`.
- `o_scl_if`  source  `if_axi_stream` with `DAT_BITS=SCL_BITS`  scalar.
- `o_log2_num_in`  out  32  job size; held stable until the next valid header.
- `o_busy`  out  1  high from header accept until the last scalar is accepted.
- `o_err`  out  1  sticky protocol error flag; cleared on the next valid header.

## Operation
- **Packet format:** beat 0 is the header and has `sop=1`; `dat[31:0]` holds `log2`. Then N = 2^log2 pairs follow, each a point beat then a scalar beat (`dat[SCL_BITS-1:0]`). The final scalar beat has `eop=1`.
- **State `HDR`:**
  - `i_host_if.rdy = ~o_pnt_if.val && ~o_scl_if.val`, so a header is never taken while outputs from the previous job are pending.
  - A beat with `sop=1` and `log2<=MAX_LOG2` loads `o_log2_num_in`, clears the element counter (33 bits) and `o_err`, then goes to `PNT`.
  - A beat with `sop=0` or `log2>MAX_LOG2` sets `o_err`. It goes to `FLUSH`, or stays in `HDR` if that beat has `eop=1`.
- **State `PNT`:**
  - `rdy = ~o_pnt_if.val || o_pnt_if.rdy`.
  - On accept, load the `o_pnt_if` register (`sop=eop=1`, `ctl/err/mod=0`) and go to `SCL`.
  - An accepted beat with `eop=1` sets `o_err` and returns to `HDR`, with no point emitted.
- **State `SCL`:**
  - `rdy = ~o_scl_if.val || o_scl_if.rdy`.
  - On accept, load the `o_scl_if` register and increment the counter.
  - If counter+1 == N and `eop=1`: go to `HDR` and drop `o_busy`.
  - If counter+1 == N and `eop=0`: set `o_err` and go to `FLUSH`.
  - If counter+1 < N and `eop=1`: set `o_err` and go to `HDR`.
  - Otherwise go to `PNT`.
- **State `FLUSH`:** `rdy=1`; beats are discarded until one with `eop=1` is accepted, then go to `HDR`.
- **Output registers:** `val` clears when `val && rdy` and no new load happens in that cycle. A load in the same cycle as the drain is allowed, which gives full throughput.
- **Emitted pairs:** points and scalars already emitted from a truncated packet are not retracted; the downstream wrapper pairs them.

## Timing
- **Reset:** all outputs reset to 0 (`val`, `sop`, `eop`, `dat`, `o_log2_num_in`, `o_busy`, `o_err`) and the state goes to `HDR`. Reset asserted mid-packet drops all partial state; the host must restart from a header.
- **Latency:** 1 cycle from input accept to the output `val` rising.
- **Throughput:** one beat per cycle while downstream `rdy` stays high. A job takes 1 + 2N host cycles.
- **Output dependency:** `o_pnt_if.val` asserts one cycle before the matching `o_scl_if.val`. The downstream join consumes both together, so the point register may stall while the scalar arrives; this cannot deadlock because `PNT` only waits on the point register.
- **Input stalls:** `i_host_if` can stall, i.e. `val` low for any number of cycles, in any state, with no effect.
- **Signal ownership:** `o_busy` and `o_err` are registered. `o_log2_num_in` updates in the cycle after the header is accepted.

## Structure
- **`bn128_pkg` additions:** `MULTIEXP_MAX_LOG2`, the header field offsets `HDR_LOG2_LO`/`HDR_LOG2_HI`, and the state enum `demux_state_t`.
- **Sub-module:** `axis_out_reg` — a single-entry source register with load/drain and same-cycle load+drain. Instantiate it twice, once per output.

## Test plan
- **Minimal job:** header log2=0, then point (x=1, y=2), then scalar 5 with `eop`. Expect `o_log2_num_in=0`, one point (1,2), one scalar 5, `o_busy` 1 then 0, and `o_err=0`.
- **Streaming:** log2=3 with `rdy` held high. Expect 8 points and 8 scalars in order, 17 host cycles with no bubbles, and the scalar `dat` equal to the input index.
- **Backpressure:** log2=2 with random `o_pnt_if.rdy` and `o_scl_if.rdy`. Expect no lost or duplicated beats and output order preserved; `i_host_if.rdy` low whenever the target register is full and not draining.
- **Errors:**
  - log2=25: expect `o_err=1` and all beats flushed to `eop`.
  - Missing `sop` on the header: expect `o_err=1`.
  - Early `eop` on the 2nd scalar of a log2=2 job: expect `o_err=1` and a return to `HDR`.
  - After each case, a following valid header clears `o_err`.
- **Async reset:** assert `i_rst_n` low mid-job in `PNT` with a point pending. Expect all outputs 0 immediately without waiting for a clock edge, then a fresh log2=1 job completes correctly.
